cu_fsm: RTL

- Multi-cycle control unit that sits directly upstream of ram_datapath. It owns the PC and instruction register.
- Fetches 32-bit LEGv8 instructions from a synchronous instruction ROM and decodes them.
- Drives ram_datapath's full control word (SA/SB/DA/FS/K/K_SEL/PC_SEL/C0/EN_ALU/EN_B/EN_ADDR/W/WE/OE/CU) one phase at a time.
- Consumes ram_datapath's Status and PC_in for conditional and register branches.

---
 rtl/cu_pkg.sv | 71 +++++++
 rtl/cu_if.sv | 40 ++++
 rtl/cu_decode.sv | 109 ++++++++++
 rtl/cu_fsm.sv | 115 +++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cu_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        STOP
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_AND, I_ORR,
        I_ADDI, I_SUBI,
        I_LDUR, I_STUR,
        I_B, I_CBZ, I_BR,
        I_HALT, I_ILL
    } iclass_t;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_BR   = 11'h6B0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    localparam logic [4:0]  FS_ADD  = 5'b01000;
    localparam logic [4:0]  FS_SUB  = 5'b01010;
    localparam logic [4:0]  FS_AND  = 5'b00000;
    localparam logic [4:0]  FS_ORR  = 5'b00100;

    localparam logic [4:0]  REG_ZR     = 5'd31;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // Full datapath control word
    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic [4:0]  fs;
        logic [63:0] k;
        logic        k_sel;
        logic        pc_sel;
        logic        c0;
        logic        en_alu;
        logic        en_b;
        logic        en_addr;
        logic        w;
        logic        we;
        logic        oe;
    } ctrl_t;

    // Control word that leaves the datapath untouched
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c        = '0;
        c.sa     = REG_ZR;
        c.sb     = REG_ZR;
        c.da     = REG_ZR;
        return c;
    endfunction

endpackage

// File: rtl/cu_if.sv
// Bundle between the control unit, its instruction ROM and ram_datapath.
// Latency: n/a (wires only).
// Backpressure: none; ROM answers one cycle after the address, datapath is always ready.
// Ports: master = control unit (drives ROM address and control word, reads
//        instruction data, Status and PC_in); slave = ROM/datapath side.
interface cu_if;
    logic [31:0] instr_rdata;
    logic [3:0]  Status;
    logic [63:0] PC_in;
    logic [63:0] instr_addr;
    logic [4:0]  SA;
    logic [4:0]  SB;
    logic [4:0]  DA;
    logic [4:0]  FS;
    logic [63:0] K;
    logic        K_SEL;
    logic        PC_SEL;
    logic        C0;
    logic        EN_ALU;
    logic        EN_B;
    logic        EN_ADDR;
    logic        W;
    logic        WE;
    logic        OE;
    logic [63:0] CU;
    logic        halted;
    logic        illegal;

    modport master (
        input  instr_rdata, Status, PC_in,
        output instr_addr, SA, SB, DA, FS, K, K_SEL, PC_SEL, C0,
               EN_ALU, EN_B, EN_ADDR, W, WE, OE, CU, halted, illegal
    );

    modport slave (
        output instr_rdata, Status, PC_in,
        input  instr_addr, SA, SB, DA, FS, K, K_SEL, PC_SEL, C0,
               EN_ALU, EN_B, EN_ADDR, W, WE, OE, CU, halted, illegal
    );
endinterface

// File: rtl/cu_decode.sv
// Instruction decoder: IR -> class, branch offsets, EXEC and MEM control words.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ir in; iclass, exec_cw, mem_cw, br_off (B), cbz_off (CBZ) out.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0] ir,
    output iclass_t     iclass,
    output ctrl_t       exec_cw,
    output ctrl_t       mem_cw,
    output logic [63:0] br_off,
    output logic [63:0] cbz_off
);

    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] alu_imm;
    logic [63:0] d_off;

    assign rd      = ir[4:0];
    assign rn      = ir[9:5];
    assign rm      = ir[20:16];
    assign alu_imm = {52'd0, ir[21:10]};
    assign d_off   = {{55{ir[20]}}, ir[20:12]};
    assign br_off  = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign cbz_off = {{43{ir[23]}}, ir[23:5], 2'b00};

    // Widest opcode first so the shorter prefixes cannot shadow it
    always_comb begin
        iclass = I_ILL;
        if (ir == HALT_INSTR)             iclass = I_HALT;
        else if (ir[31:21] == OP_ADD)     iclass = I_ADD;
        else if (ir[31:21] == OP_SUB)     iclass = I_SUB;
        else if (ir[31:21] == OP_AND)     iclass = I_AND;
        else if (ir[31:21] == OP_ORR)     iclass = I_ORR;
        else if (ir[31:21] == OP_LDUR)    iclass = I_LDUR;
        else if (ir[31:21] == OP_STUR)    iclass = I_STUR;
        else if (ir[31:21] == OP_BR)      iclass = I_BR;
        else if (ir[31:22] == OP_ADDI)    iclass = I_ADDI;
        else if (ir[31:22] == OP_SUBI)    iclass = I_SUBI;
        else if (ir[31:24] == OP_CBZ)     iclass = I_CBZ;
        else if (ir[31:26] == OP_B)       iclass = I_B;
    end

    always_comb begin
        exec_cw = idle_ctrl();
        mem_cw  = idle_ctrl();
        case (iclass)
            I_ADD, I_SUB, I_AND, I_ORR, I_ADDI, I_SUBI: begin
                exec_cw.sa     = rn;
                exec_cw.da     = rd;
                exec_cw.en_alu = 1'b1;
                exec_cw.w      = 1'b1;
                if (iclass == I_ADDI || iclass == I_SUBI) begin
                    exec_cw.sb    = REG_ZR;
                    exec_cw.k     = alu_imm;
                    exec_cw.k_sel = 1'b1;
                end else begin
                    exec_cw.sb    = rm;
                end
                // Subtraction is A + ~B + 1, so carry-in rides with FS_SUB
                exec_cw.c0 = (iclass == I_SUB || iclass == I_SUBI);
                case (iclass)
                    I_AND:         exec_cw.fs = FS_AND;
                    I_ORR:         exec_cw.fs = FS_ORR;
                    I_SUB, I_SUBI: exec_cw.fs = FS_SUB;
                    default:       exec_cw.fs = FS_ADD;
                endcase
            end
            I_LDUR: begin
                exec_cw.sa      = rn;
                exec_cw.da      = rd;
                exec_cw.k       = d_off;
                exec_cw.k_sel   = 1'b1;
                exec_cw.fs      = FS_ADD;
                exec_cw.en_addr = 1'b1;
                exec_cw.oe      = 1'b1;
                // Register write only once the RAM read data has settled
                mem_cw          = exec_cw;
                mem_cw.w        = 1'b1;
            end
            I_STUR: begin
                exec_cw.sa      = rn;
                exec_cw.sb      = rd;
                exec_cw.k       = d_off;
                exec_cw.k_sel   = 1'b1;
                exec_cw.fs      = FS_ADD;
                exec_cw.en_addr = 1'b1;
                exec_cw.en_b    = 1'b1;
                exec_cw.we      = 1'b1;
                mem_cw          = exec_cw;
            end
            I_CBZ: begin
                // Pass Rt through the ALU (Rt + 0) to produce the Z flag
                exec_cw.sa    = rd;
                exec_cw.k_sel = 1'b1;
                exec_cw.fs    = FS_ADD;
            end
            I_BR: begin
                exec_cw.sa     = rn;
                exec_cw.pc_sel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// Multi-cycle LEGv8 control unit: owns pc/IR, sequences FETCH-DECODE-EXEC(-MEM).
// Latency: 3 cycles per ALU/branch instruction, 4 per LDUR/STUR; STOP holds until rst.
// Backpressure: none; ROM data is taken the cycle after the address.
// Ports: clk, rst (sync, active-high); bus (cu_if.master) carries ROM address/data,
//        datapath Status/PC_in, the full control word, CU (=pc), halted, illegal.
module cu_fsm
    import cu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic clk,
    input  logic rst,
    cu_if.master bus
);

    state_t      state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic [31:0] ir, ir_nxt;
    logic        halted_q, halted_nxt;
    logic        illegal_q, illegal_nxt;
    ctrl_t       cw;

    iclass_t     iclass;
    ctrl_t       exec_cw;
    ctrl_t       mem_cw;
    logic [63:0] br_off;
    logic [63:0] cbz_off;

    cu_decode u_decode (
        .ir      (ir),
        .iclass  (iclass),
        .exec_cw (exec_cw),
        .mem_cw  (mem_cw),
        .br_off  (br_off),
        .cbz_off (cbz_off)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            halted_q  <= halted_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        halted_nxt  = halted_q;
        illegal_nxt = illegal_q;
        cw          = idle_ctrl();
        case (state)
            FETCH:  state_nxt = DECODE;
            DECODE: begin
                ir_nxt    = bus.instr_rdata;
                state_nxt = EXEC;
            end
            EXEC: begin
                cw        = exec_cw;
                state_nxt = FETCH;
                case (iclass)
                    I_LDUR, I_STUR: state_nxt = MEM;   // pc moves at end of MEM
                    I_B:            pc_nxt = pc + br_off;
                    I_CBZ:          pc_nxt = bus.Status[0] ? pc + cbz_off : pc + 64'd4;
                    I_BR:           pc_nxt = bus.PC_in;
                    I_HALT: begin
                        state_nxt  = STOP;
                        halted_nxt = 1'b1;
                    end
                    I_ILL: begin
                        state_nxt   = STOP;
                        illegal_nxt = 1'b1;
                    end
                    default:        pc_nxt = pc + 64'd4;
                endcase
            end
            MEM: begin
                cw        = mem_cw;
                pc_nxt    = pc + 64'd4;
                state_nxt = FETCH;
            end
            STOP:    ;
            default: state_nxt = FETCH;
        endcase
    end

    assign bus.instr_addr = pc;
    assign bus.CU         = pc;
    assign bus.SA         = cw.sa;
    assign bus.SB         = cw.sb;
    assign bus.DA         = cw.da;
    assign bus.FS         = cw.fs;
    assign bus.K          = cw.k;
    assign bus.K_SEL      = cw.k_sel;
    assign bus.PC_SEL     = cw.pc_sel;
    assign bus.C0         = cw.c0;
    assign bus.EN_ALU     = cw.en_alu;
    assign bus.EN_B       = cw.en_b;
    assign bus.EN_ADDR    = cw.en_addr;
    assign bus.W          = cw.w;
    assign bus.WE         = cw.we;
    assign bus.OE         = cw.oe;
    assign bus.halted     = halted_q;
    assign bus.illegal    = illegal_q;

endmodule
